ahb_sram_satellite: RTL

AHB_SRAM_SATELLITE -- requirements
Module: ahb_sram_satellite

---
 rtl/common_types_pkg.sv | 27 ++
 rtl/ahb_sram_satellite_if.sv | 27 ++
 rtl/ahb_sram_satellite_sram_byte_array.sv | 25 ++
 rtl/ahb_sram_satellite.sv | 138 +++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared AHB-lite constants and types for the SRAM satellite slice.
package common_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  // Byte-lane enables for a little-endian 32-bit data bus; illegal size selects nothing.
  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_satellite_if.sv
// AHB-lite slave port bundle for the SRAM satellite (hready is driven by the bus fabric).
interface ahb_sram_satellite_if;
  import common_types_pkg::*;

  logic       hsel;
  word_t      haddr;
  logic [1:0] htrans;
  logic [1:0] hsize;
  logic       hwrite;
  logic [2:0] hburst;
  word_t      hwdata;
  logic       hready;
  logic       hreadyout;
  logic       hresp;
  word_t      hrdata;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_sram_satellite_sram_byte_array.sv
// Word-organised SRAM with per-byte write enables and combinational read; contents are never reset.
module sram_byte_array
  import common_types_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_satellite.sv
// AHB-lite SRAM slave: optional wait states, two-cycle ERROR response, byte-lane writes.
module ahb_sram_satellite
  import common_types_pkg::*;
#(
  parameter word_t       ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  ahb_sram_satellite_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  word_t      haddr_q, haddr_d;
  logic [1:0] hsize_q, hsize_d;
  logic       hwrite_q, hwrite_d;
  logic       pend_q, pend_d;
  logic       hreadyout_q, hreadyout_d;
  logic       hresp_q, hresp_d;

  word_t      req_off, addr_off, rdata;
  logic       accept, req_err, done;
  logic [3:0] mem_we;
  logic       unused_bits;

  assign accept = bus.hsel && bus.hready
               && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ)
               && (state_q == S_IDLE || state_q == S_ERR2);

  assign req_off = bus.haddr - ADDR_BASE;
  assign req_err = (bus.haddr < ADDR_BASE)
                || ({1'b0, req_off} >= SPAN)
                || (bus.hsize == 2'b11)
                || (bus.hsize == HSIZE_HALF && bus.haddr[0])
                || (bus.hsize == HSIZE_WORD && bus.haddr[1:0] != 2'b00);

  // An OKAY data phase is live from acceptance until the cycle hreadyout goes high.
  assign done = pend_q && hreadyout_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    pend_d      = pend_q && !done;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    unique case (state_q)
      S_WAIT: begin
        if (wcnt_q <= 4'd1) begin
          state_d     = S_IDLE;
          wcnt_d      = '0;
          hreadyout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d     = S_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept) begin
          haddr_d  = bus.haddr;
          hsize_d  = bus.hsize;
          hwrite_d = bus.hwrite;
          if (req_err) begin
            state_d     = S_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            pend_d = 1'b1;
            if (WS != 4'd0) begin
              state_d     = S_WAIT;
              wcnt_d      = WS;
              hreadyout_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      pend_q      <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      pend_q      <= pend_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign addr_off = haddr_q - ADDR_BASE;
  assign mem_we   = (done && hwrite_q) ? byte_lanes(hsize_q, haddr_q[1:0]) : '0;

  sram_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_off[AW+1:2]),
    .wdata (bus.hwdata),
    .rdata (rdata)
  );

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = (done && !hwrite_q) ? rdata : '0;

  assign unused_bits = ^{addr_off[31:AW+2], addr_off[1:0], bus.hburst};

endmodule
